// File: rtl/ddr3_axi_pmem_if.sv
// rtl/ddr3_axi_pmem_if.sv - 32-bit AXI4 port between the retime slice and the pmem responder
interface ddr3_axi_pmem_if;
    logic        axi_awvalid_i;
    logic        axi_awready_o;
    logic [31:0] axi_awaddr_i;
    logic [3:0]  axi_awid_i;
    logic [7:0]  axi_awlen_i;
    logic [1:0]  axi_awburst_i;
    logic        axi_wvalid_i;
    logic        axi_wready_o;
    logic [31:0] axi_wdata_i;
    logic [3:0]  axi_wstrb_i;
    logic        axi_wlast_i;
    logic        axi_bvalid_o;
    logic        axi_bready_i;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o;
    logic        axi_arvalid_i;
    logic        axi_arready_o;
    logic [31:0] axi_araddr_i;
    logic [3:0]  axi_arid_i;
    logic [7:0]  axi_arlen_i;
    logic [1:0]  axi_arburst_i;
    logic        axi_rvalid_o;
    logic        axi_rready_i;
    logic [31:0] axi_rdata_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic        axi_rlast_o;

    modport slave (
        input  axi_awvalid_i, axi_awaddr_i, axi_awid_i, axi_awlen_i, axi_awburst_i,
        input  axi_wvalid_i, axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_bready_i,
        input  axi_arvalid_i, axi_araddr_i, axi_arid_i, axi_arlen_i, axi_arburst_i, axi_rready_i,
        output axi_awready_o, axi_wready_o, axi_bvalid_o, axi_bresp_o, axi_bid_o,
        output axi_arready_o, axi_rvalid_o, axi_rdata_o, axi_rresp_o, axi_rid_o, axi_rlast_o
    );

    modport master (
        output axi_awvalid_i, axi_awaddr_i, axi_awid_i, axi_awlen_i, axi_awburst_i,
        output axi_wvalid_i, axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_bready_i,
        output axi_arvalid_i, axi_araddr_i, axi_arid_i, axi_arlen_i, axi_arburst_i, axi_rready_i,
        input  axi_awready_o, axi_wready_o, axi_bvalid_o, axi_bresp_o, axi_bid_o,
        input  axi_arready_o, axi_rvalid_o, axi_rdata_o, axi_rresp_o, axi_rid_o, axi_rlast_o
    );
endinterface

// File: rtl/ddr3_axi_pmem.sv
// rtl/ddr3_axi_pmem.sv - AXI4 responder splitting one burst at a time into single-beat RAM requests
module ddr3_axi_pmem #(
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ddr3_axi_pmem_if.slave axi,
    output logic [3:0]     ram_wr_o,
    output logic           ram_rd_o,
    output logic [7:0]     ram_len_o,
    output logic [31:0]    ram_addr_o,
    output logic [31:0]    ram_write_data_o,
    input  logic           ram_accept_i,
    input  logic           ram_ack_i,
    input  logic           ram_error_i,
    input  logic [31:0]    ram_read_data_i
);
    localparam int PW = $clog2(RD_FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRESP, S_READ} state_t;
    state_t r_state, w_next_state;

    logic          r_last_grant_rd;
    logic [31:0]   r_addr;
    logic [3:0]    r_id;
    logic [7:0]    r_len;
    logic [1:0]    r_burst;
    logic [8:0]    r_issued, r_acked, r_rbeat;
    logic          r_err;
    logic [31:0]   r_fifo_data [RD_FIFO_DEPTH];
    logic          r_fifo_err  [RD_FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;

    logic        w_grant_wr, w_aw_hs, w_ar_hs, w_issue_active, w_req, w_req_acc;
    logic        w_ack, w_last_ack, w_push, w_pop, w_rlast;
    logic [8:0]  w_in_flight;
    logic [9:0]  w_rd_occupancy;
    logic [31:0] w_wrap_mask, w_addr_inc, w_next_addr;

    assign w_grant_wr     = axi.axi_awvalid_i & (~axi.axi_arvalid_i | r_last_grant_rd);
    assign w_aw_hs        = (r_state == S_IDLE) & w_grant_wr;
    assign w_ar_hs        = (r_state == S_IDLE) & axi.axi_arvalid_i & ~w_grant_wr;
    assign w_issue_active = r_issued <= {1'b0, r_len};
    assign w_in_flight    = r_issued - r_acked;
    // Outstanding RAM reads plus buffered beats never exceed the FIFO, so every ack has a slot.
    assign w_rd_occupancy = {1'b0, w_in_flight} + 10'(r_count);
    assign w_req          = w_issue_active &
                            (((r_state == S_WRITE) & axi.axi_wvalid_i) |
                             ((r_state == S_READ) & (w_rd_occupancy < 10'(RD_FIFO_DEPTH))));
    assign w_req_acc      = w_req & ram_accept_i;
    assign w_ack          = ram_ack_i & (w_in_flight != 9'd0) &
                            ((r_state == S_WRITE) | (r_state == S_READ));
    assign w_last_ack     = w_ack & (r_acked == {1'b0, r_len});
    assign w_push         = w_ack & (r_state == S_READ);
    assign w_pop          = (r_count != '0) & axi.axi_rready_i;
    assign w_rlast        = r_rbeat == {1'b0, r_len};

    // WRAP keeps the bits above the (len+1)*4 window and increments only inside it.
    assign w_wrap_mask = {22'd0, r_len, 2'b11};
    assign w_addr_inc  = r_addr + 32'd4;
    always_comb begin
        w_next_addr = w_addr_inc;
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
            2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
            default: w_next_addr = w_addr_inc;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_aw_hs) w_next_state = S_WRITE;
                     else if (w_ar_hs) w_next_state = S_READ;
            S_WRITE: if (w_last_ack) w_next_state = S_WRESP;
            S_WRESP: if (axi.axi_bready_i) w_next_state = S_IDLE;
            S_READ:  if (w_pop & w_rlast) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        axi.axi_awready_o = w_aw_hs;
        axi.axi_arready_o = w_ar_hs;
        axi.axi_wready_o  = (r_state == S_WRITE) & w_issue_active & ram_accept_i;
        axi.axi_bvalid_o  = r_state == S_WRESP;
        axi.axi_bresp_o   = r_err ? 2'b10 : 2'b00;
        axi.axi_bid_o     = r_id;
        axi.axi_rvalid_o  = r_count != '0;
        axi.axi_rdata_o   = r_fifo_data[r_rptr];
        axi.axi_rresp_o   = r_fifo_err[r_rptr] ? 2'b10 : 2'b00;
        axi.axi_rid_o     = r_id;
        axi.axi_rlast_o   = w_rlast;
        ram_wr_o          = 4'd0;
        if ((r_state == S_WRITE) & w_req) ram_wr_o = axi.axi_wstrb_i;
        ram_rd_o          = (r_state == S_READ) & w_req;
        ram_len_o         = w_issue_active ? (r_len - r_issued[7:0]) : 8'd0;
        ram_addr_o        = {r_addr[31:2], 2'b00};
        ram_write_data_o  = axi.axi_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant_rd <= 1'b1;
            r_addr   <= '0;
            r_id     <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_issued <= '0;
            r_acked  <= '0;
            r_rbeat  <= '0;
            r_err    <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            if (w_aw_hs || w_ar_hs) begin
                r_last_grant_rd <= w_ar_hs;
                r_addr   <= w_aw_hs ? axi.axi_awaddr_i  : axi.axi_araddr_i;
                r_id     <= w_aw_hs ? axi.axi_awid_i    : axi.axi_arid_i;
                r_len    <= w_aw_hs ? axi.axi_awlen_i   : axi.axi_arlen_i;
                r_burst  <= w_aw_hs ? axi.axi_awburst_i : axi.axi_arburst_i;
                r_issued <= '0;
                r_acked  <= '0;
                r_rbeat  <= '0;
                r_err    <= 1'b0;
            end else begin
                if (w_req_acc) begin
                    r_addr   <= w_next_addr;
                    r_issued <= r_issued + 9'd1;
                end
                if (w_ack) begin
                    r_acked <= r_acked + 9'd1;
                    if (ram_error_i) r_err <= 1'b1;
                end
                if (w_pop) r_rbeat <= r_rbeat + 9'd1;
            end
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= ram_read_data_i;
            r_fifo_err[r_wptr]  <= ram_error_i;
        end
    end
endmodule

// File: tb/tb_ddr3_axi_pmem.sv
// tb/tb_ddr3_axi_pmem.sv - scoreboard bench for ddr3_axi_pmem with an in-order RAM model
module tb_ddr3_axi_pmem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [3:0]  ram_wr_o;
    logic        ram_rd_o;
    logic [7:0]  ram_len_o;
    logic [31:0] ram_addr_o, ram_write_data_o;
    logic        ram_accept_i, ram_ack_i, ram_error_i;
    logic [31:0] ram_read_data_i;
    logic        accept_en;

    ddr3_axi_pmem_if axi();

    assign ram_accept_i = accept_en & (ram_rd_o | (|ram_wr_o));

    ddr3_axi_pmem #(.RD_FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .axi(axi),
        .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_len_o(ram_len_o),
        .ram_addr_o(ram_addr_o), .ram_write_data_o(ram_write_data_o),
        .ram_accept_i(ram_accept_i), .ram_ack_i(ram_ack_i), .ram_error_i(ram_error_i),
        .ram_read_data_i(ram_read_data_i)
    );

    typedef struct {logic [31:0] addr; logic [3:0] wr; logic rd; logic [31:0] data; logic [7:0] len;} req_t;
    typedef struct {logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last;} rbeat_t;
    typedef struct {logic [1:0] resp; logic [3:0] id;} b_t;
    typedef struct {int due; logic err; logic rd; logic [31:0] data;} pend_t;

    req_t   exp_req[$];
    rbeat_t exp_r[$];
    b_t     exp_b[$];
    pend_t  pend[$];

    int checks = 0, failures = 0;
    int ncyc = 0, lat = 1;
    int n_rd_acc = 0, n_rd_acked = 0, n_r_delivered = 0;
    int r_target = 0, ack_target = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input logic [1:0] burst, input int i);
        logic [31:0] size, base;
        size = 32'((len + 1) * 4);
        base = a - (a % size);
        case (burst)
            2'b00:   return a;
            2'b10:   return base + ((a - base + 32'(4 * i)) % size);
            default: return a + 32'(4 * i);
        endcase
    endfunction

    task automatic queue_write(input logic [31:0] a, input logic [3:0] id, input int len, input logic [1:0] burst,
                               input logic [3:0] strb, input logic [31:0] dbase);
        logic any_err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            logic [31:0] ba = beat_addr(a, len, burst, i);
            exp_req.push_back('{addr: ba, wr: strb, rd: 1'b0, data: dbase + 32'(i), len: 8'(len - i)});
            if (ba == err_addr) any_err = 1'b1;
        end
        exp_b.push_back('{resp: any_err ? 2'b10 : 2'b00, id: id});
    endtask

    task automatic queue_read(input logic [31:0] a, input logic [3:0] id, input int len, input logic [1:0] burst);
        for (int i = 0; i <= len; i++) begin
            logic [31:0] ba = beat_addr(a, len, burst, i);
            exp_req.push_back('{addr: ba, wr: 4'd0, rd: 1'b1, data: 32'd0, len: 8'(len - i)});
            exp_r.push_back('{data: rd_val(ba), resp: (ba == err_addr) ? 2'b10 : 2'b00, id: id, last: (i == len)});
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return axi.axi_awready_o;
            1: return axi.axi_arready_o;
            2: return axi.axi_wready_o;
            3: return exp_b.size() == 0;
            4: return exp_r.size() == 0;
            5: return n_r_delivered >= r_target;
            6: return axi.axi_bvalid_o;
            7: return n_rd_acked >= ack_target;
            default: return 1'b0;
        endcase
    endfunction

    // Waits at falling edges for condition k, then steps past the following rising edge.
    task automatic wait_for(input int k, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(k) && n < 300);
        check(32'(sig(k)), 32'd1, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic send_w(input int len, input logic [3:0] strb, input logic [31:0] dbase);
        for (int i = 0; i <= len; i++) begin
            axi.axi_wvalid_i = 1'b1;
            axi.axi_wdata_i  = dbase + 32'(i);
            axi.axi_wstrb_i  = strb;
            axi.axi_wlast_i  = (i == len);
            wait_for(2, "w_handshake");
        end
        axi.axi_wvalid_i = 1'b0;
        axi.axi_wlast_i  = 1'b0;
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [3:0] id, input int len, input logic [1:0] burst);
        axi.axi_awaddr_i = a; axi.axi_awid_i = id; axi.axi_awlen_i = 8'(len); axi.axi_awburst_i = burst;
        axi.axi_awvalid_i = 1'b1;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [3:0] id, input int len, input logic [1:0] burst);
        axi.axi_araddr_i = a; axi.axi_arid_i = id; axi.axi_arlen_i = 8'(len); axi.axi_arburst_i = burst;
        axi.axi_arvalid_i = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] id, input int len, input logic [1:0] burst,
                            input logic [3:0] strb, input logic [31:0] dbase);
        queue_write(a, id, len, burst, strb, dbase);
        set_aw(a, id, len, burst);
        wait_for(0, "aw_handshake");
        axi.axi_awvalid_i = 1'b0;
        send_w(len, strb, dbase);
        wait_for(3, "b_done");
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input int len, input logic [1:0] burst);
        queue_read(a, id, len, burst);
        set_ar(a, id, len, burst);
        wait_for(1, "ar_handshake");
        axi.axi_arvalid_i = 1'b0;
        wait_for(4, "r_done");
    endtask

    task automatic monitor_loop();
        req_t er;
        rbeat_t eb;
        b_t ebb;
        forever begin
            @(negedge clk);
            ram_ack_i   = 1'b0;
            ram_error_i = 1'b0;
            if (rst_i) begin
                pend.delete();
            end else begin
                if (pend.size() > 0 && pend[0].due <= ncyc) begin
                    ram_ack_i       = 1'b1;
                    ram_error_i     = pend[0].err;
                    ram_read_data_i = pend[0].data;
                    if (pend[0].rd) n_rd_acked++;
                    void'(pend.pop_front());
                end
                if (ram_accept_i) begin
                    if (exp_req.size() == 0) begin
                        check(ram_addr_o, 32'hFFFF_FFFF, "unexpected_ram_request");
                    end else begin
                        er = exp_req.pop_front();
                        check(ram_addr_o, er.addr, "ram_addr");
                        check(32'(ram_wr_o), 32'(er.wr), "ram_wr");
                        check(32'(ram_rd_o), 32'(er.rd), "ram_rd");
                        check(32'(ram_len_o), 32'(er.len), "ram_len");
                        if (er.wr != 4'd0) check(ram_write_data_o, er.data, "ram_wdata");
                    end
                    if (ram_rd_o) n_rd_acc++;
                    pend.push_back('{due: ncyc + lat, err: (ram_addr_o == err_addr), rd: ram_rd_o,
                                     data: rd_val(ram_addr_o)});
                end
                if (axi.axi_rvalid_o && axi.axi_rready_i) begin
                    n_r_delivered++;
                    if (exp_r.size() == 0) begin
                        check(axi.axi_rdata_o, 32'hFFFF_FFFF, "unexpected_r_beat");
                    end else begin
                        eb = exp_r.pop_front();
                        check(axi.axi_rdata_o, eb.data, "rdata");
                        check(32'(axi.axi_rresp_o), 32'(eb.resp), "rresp");
                        check(32'(axi.axi_rid_o), 32'(eb.id), "rid");
                        check(32'(axi.axi_rlast_o), 32'(eb.last), "rlast");
                    end
                end
                if (axi.axi_bvalid_o && axi.axi_bready_i) begin
                    if (exp_b.size() == 0) begin
                        check(32'(axi.axi_bid_o), 32'hFFFF_FFFF, "unexpected_b");
                    end else begin
                        ebb = exp_b.pop_front();
                        check(32'(axi.axi_bresp_o), 32'(ebb.resp), "bresp");
                        check(32'(axi.axi_bid_o), 32'(ebb.id), "bid");
                    end
                end
            end
            ncyc++;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        accept_en = 1'b1;
        ram_ack_i = 1'b0; ram_error_i = 1'b0; ram_read_data_i = 32'd0;
        axi.axi_awvalid_i = 0; axi.axi_awaddr_i = 0; axi.axi_awid_i = 0; axi.axi_awlen_i = 0; axi.axi_awburst_i = 0;
        axi.axi_wvalid_i = 0; axi.axi_wdata_i = 0; axi.axi_wstrb_i = 0; axi.axi_wlast_i = 0; axi.axi_bready_i = 1;
        axi.axi_arvalid_i = 0; axi.axi_araddr_i = 0; axi.axi_arid_i = 0; axi.axi_arlen_i = 0; axi.axi_arburst_i = 0;
        axi.axi_rready_i = 1;
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check(32'(axi.axi_awready_o), 0, "rst_awready");
        check(32'(axi.axi_arready_o), 0, "rst_arready");
        check(32'(axi.axi_bvalid_o), 0, "rst_bvalid");
        check(32'(axi.axi_rvalid_o), 0, "rst_rvalid");
        check(32'(ram_wr_o), 0, "rst_ram_wr");
        check(32'(ram_rd_o), 0, "rst_ram_rd");
        check(32'(ram_len_o), 0, "rst_ram_len");
        check(ram_addr_o, 0, "rst_ram_addr");
        @(posedge clk); #1;

        lat = 1;
        do_write(32'h100, 4'h5, 0, 2'b01, 4'hF, 32'hDEAD_BEEF);
        do_write(32'h400, 4'h2, 2, 2'b00, 4'h3, 32'h0A0B_0C00);
        lat = 3;
        do_read(32'h1000, 4'h9, 3, 2'b01);
        lat = 1;
        do_read(32'h2018, 4'h3, 3, 2'b10);

        // Backpressure on R: issue must stop once four beats are outstanding or buffered.
        lat = 2;
        queue_read(32'h3000, 4'h6, 7, 2'b01);
        set_ar(32'h3000, 4'h6, 7, 2'b01);
        wait_for(1, "stall_ar_handshake");
        axi.axi_arvalid_i = 1'b0;
        r_target = n_r_delivered + 1;
        wait_for(5, "stall_first_beat");
        axi.axi_rready_i = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check(32'((n_rd_acc - n_r_delivered) <= 4), 1, "stall_occupancy_bound");
        end
        check(32'(n_rd_acc - n_r_delivered), 4, "stall_occupancy_full");
        check(32'(ram_rd_o), 0, "stall_rd_stopped");
        axi.axi_rready_i = 1'b1;
        wait_for(4, "stall_r_done");

        // Two AW/AR ties: write wins first, read wins second, then the pending write.
        lat = 1;
        err_addr = 32'h308;
        queue_write(32'h300, 4'h1, 3, 2'b01, 4'hF, 32'h1111_0000);
        queue_read(32'h500, 4'h7, 1, 2'b01);
        queue_write(32'h600, 4'h2, 0, 2'b01, 4'hF, 32'h2222_0000);
        set_aw(32'h300, 4'h1, 3, 2'b01);
        set_ar(32'h500, 4'h7, 1, 2'b01);
        @(negedge clk);
        check(32'(axi.axi_awready_o), 1, "tie1_awready");
        check(32'(axi.axi_arready_o), 0, "tie1_arready");
        @(posedge clk); #1;
        axi.axi_awvalid_i = 1'b0;
        send_w(3, 4'hF, 32'h1111_0000);
        wait_for(6, "tie_b_first");
        set_aw(32'h600, 4'h2, 0, 2'b01);
        @(negedge clk);
        check(32'(axi.axi_arready_o), 1, "tie2_arready");
        check(32'(axi.axi_awready_o), 0, "tie2_awready");
        @(posedge clk); #1;
        axi.axi_arvalid_i = 1'b0;
        wait_for(0, "tie_aw_after_read");
        axi.axi_awvalid_i = 1'b0;
        send_w(0, 4'hF, 32'h2222_0000);
        wait_for(3, "tie_b_second");
        wait_for(4, "tie_r_done");
        err_addr = 32'hFFFF_FFFF;

        // Reset with two beats parked in the read FIFO.
        axi.axi_rready_i = 1'b0;
        queue_read(32'h700, 4'h4, 1, 2'b01);
        ack_target = n_rd_acked + 2;
        set_ar(32'h700, 4'h4, 1, 2'b01);
        wait_for(1, "rst_ar_handshake");
        axi.axi_arvalid_i = 1'b0;
        wait_for(7, "rst_two_acks");
        @(negedge clk);
        check(32'(axi.axi_rvalid_o), 1, "pre_rst_rvalid");
        @(posedge clk); #1;
        rst_i = 1'b1;
        exp_r.delete();
        exp_req.delete();
        @(posedge clk); #1;
        rst_i = 1'b0;
        axi.axi_rready_i = 1'b1;
        @(negedge clk);
        check(32'(axi.axi_rvalid_o), 0, "post_rst_rvalid");
        check(32'(ram_rd_o), 0, "post_rst_ram_rd");
        check(ram_addr_o, 0, "post_rst_ram_addr");
        @(posedge clk); #1;
        do_write(32'h800, 4'hA, 1, 2'b01, 4'hF, 32'h3333_0000);

        repeat (5) @(posedge clk);
        check(32'(exp_req.size()), 0, "leftover_ram_requests");
        check(32'(exp_b.size()), 0, "leftover_b");
        check(32'(exp_r.size()), 0, "leftover_r");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
